// File: rtl/systolic_rect_dpath.sv
`timescale 1ns / 1ps
// systolic_rect_dpath: ROWS x COLS systolic multiply-accumulate array fed by
// per-row x FIFOs and per-column w FIFOs. Finished sums are snapshotted into a
// shadow buffer and streamed out row-major over a valid/ready port, so the
// array can start on the next tile while the previous one drains.

module systolic_rect_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         push_ok;
    logic         pop_ok;

    // The extra pointer bit tells full from empty when the addresses match.
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = (wp == rp);
    assign head    = mem[rp[AW-1:0]];
    assign push_ok = wen && !full;
    assign pop_ok  = pop && !empty;

    // Pointer update; a push on full is dropped even when a pop happens too.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
        end
    end

    // Storage write, kept out of the reset path.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// Drain FSM states:
//   state    | meaning
//   ST_IDLE  | no drain in progress, waiting for drain_start
//   ST_DRAIN | streaming the shadow buffer, one beat per handshake
module systolic_rect_dpath #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int NBITS      = 16,
    parameter int DBITS      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       mac_en,
    input  logic                                       acc_clr,
    input  logic [ROWS*NBITS-1:0]                      x_in,
    input  logic [ROWS-1:0]                            x_wen,
    input  logic [ROWS-1:0]                            x_ren,
    output logic [ROWS-1:0]                            x_full,
    output logic [ROWS-1:0]                            x_empty,
    input  logic [COLS*NBITS-1:0]                      w_in,
    input  logic [COLS-1:0]                            w_wen,
    input  logic [COLS-1:0]                            w_ren,
    output logic [COLS-1:0]                            w_full,
    output logic [COLS-1:0]                            w_empty,
    input  logic                                       drain_start,
    output logic                                       drain_busy,
    output logic                                       out_val,
    input  logic                                       out_rdy,
    output logic [NBITS-1:0]                           out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {ST_IDLE, ST_DRAIN} drain_state_t;

    drain_state_t state;
    drain_state_t state_nxt;
    logic         snap;
    logic         adv;
    logic         last_beat;
    logic [RW-1:0] dr_row;
    logic [CW-1:0] dr_col;

    logic [NBITS-1:0] x_head [ROWS];
    logic [NBITS-1:0] w_head [COLS];
    logic [ROWS-1:0]  x_pop;
    logic [COLS-1:0]  w_pop;

    // x_reg[r][c] carries x out of column c; w_reg[r][c] carries w out of row r.
    logic signed [NBITS-1:0] x_reg  [ROWS][COLS-1];
    logic signed [NBITS-1:0] w_reg  [ROWS-1][COLS];
    logic signed [NBITS-1:0] ax     [ROWS][COLS];
    logic signed [NBITS-1:0] aw     [ROWS][COLS];
    logic signed [NBITS-1:0] incr   [ROWS][COLS];
    logic signed [NBITS-1:0] acc    [ROWS][COLS];
    logic signed [NBITS-1:0] shadow [ROWS][COLS];

    // Fixed-point product at double width, arithmetic shift, then wrap.
    function automatic logic signed [NBITS-1:0] fx_mul(input logic signed [NBITS-1:0] a,
                                                       input logic signed [NBITS-1:0] b);
        logic signed [2*NBITS-1:0] ae;
        logic signed [2*NBITS-1:0] be;
        ae = (2*NBITS)'(a);
        be = (2*NBITS)'(b);
        return NBITS'((ae * be) >>> DBITS);
    endfunction

    // Pops only happen on array steps; an empty FIFO feeds zero instead.
    assign x_pop = {ROWS{mac_en}} & x_ren & ~x_empty;
    assign w_pop = {COLS{mac_en}} & w_ren & ~w_empty;

    for (genvar i = 0; i < ROWS; i++) begin : g_xfifo
        systolic_rect_fifo #(.W(NBITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wen   (x_wen[i]),
            .wdata (x_in[i*NBITS +: NBITS]),
            .pop   (x_pop[i]),
            .head  (x_head[i]),
            .full  (x_full[i]),
            .empty (x_empty[i])
        );
    end

    for (genvar j = 0; j < COLS; j++) begin : g_wfifo
        systolic_rect_fifo #(.W(NBITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wen   (w_wen[j]),
            .wdata (w_in[j*NBITS +: NBITS]),
            .pop   (w_pop[j]),
            .head  (w_head[j]),
            .full  (w_full[j]),
            .empty (w_empty[j])
        );
    end

    // Operands seen by each PE this step and the resulting increments.
    always_comb begin
        ax   = '{default: '0};
        aw   = '{default: '0};
        incr = '{default: '0};
        for (int r = 0; r < ROWS; r++) begin
            ax[r][0] = x_pop[r] ? x_head[r] : '0;
            for (int c = 1; c < COLS; c++) ax[r][c] = x_reg[r][c-1];
        end
        for (int c = 0; c < COLS; c++) begin
            aw[0][c] = w_pop[c] ? w_head[c] : '0;
            for (int r = 1; r < ROWS; r++) aw[r][c] = w_reg[r-1][c];
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                incr[r][c] = fx_mul(ax[r][c], aw[r][c]);
    end

    // PE state: operands shift on mac_en; clear wins over accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg <= '{default: '0};
            w_reg <= '{default: '0};
            acc   <= '{default: '0};
        end else begin
            if (mac_en) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS-1; c++) x_reg[r][c] <= ax[r][c];
                for (int r = 0; r < ROWS-1; r++)
                    for (int c = 0; c < COLS; c++) w_reg[r][c] <= aw[r][c];
            end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (acc_clr)     acc[r][c] <= '0;
                    else if (mac_en) acc[r][c] <= acc[r][c] + incr[r][c];
        end
    end

    // Shadow copy takes the accumulators as they were before this edge.
    always_ff @(posedge clk) begin
        if (rst)       shadow <= '{default: '0};
        else if (snap) shadow <= acc;
    end

    assign last_beat = (dr_row == RW'(ROWS-1)) && (dr_col == CW'(COLS-1));

    // Drain state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Drain next-state: drain_start only counts in IDLE.
    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        adv       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (drain_start) begin
                    snap      = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_rdy) begin
                    adv = 1'b1;
                    if (last_beat) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Row-major beat index; returns to (0,0) after the final beat.
    always_ff @(posedge clk) begin
        if (rst || snap) begin
            dr_row <= '0;
            dr_col <= '0;
        end else if (adv) begin
            if (dr_col == CW'(COLS-1)) begin
                dr_col <= '0;
                dr_row <= last_beat ? '0 : dr_row + 1'b1;
            end else begin
                dr_col <= dr_col + 1'b1;
            end
        end
    end

    assign drain_busy = (state == ST_DRAIN);
    assign out_val    = drain_busy;
    assign out_data   = drain_busy ? shadow[dr_row][dr_col] : '0;
    assign out_row    = dr_row;
    assign out_col    = dr_col;
endmodule

// File: tb/tb_systolic_rect_dpath.sv
`timescale 1ns / 1ps
// Bench for systolic_rect_dpath (2x3 array, 4-deep FIFOs): directed tiles with
// hand-computed results plus a randomized run, all checked each cycle against
// a queue/history based reference of the array.
module tb_systolic_rect_dpath;
    localparam int R = 2, C = 3, NB = 16, DB = 8, D = 4, HMAX = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, mac_en, acc_clr, drain_start, out_rdy;
    logic [R*NB-1:0] x_in;
    logic [R-1:0]    x_wen, x_ren, x_full, x_empty;
    logic [C*NB-1:0] w_in;
    logic [C-1:0]    w_wen, w_ren, w_full, w_empty;
    logic            drain_busy, out_val;
    logic [NB-1:0]   out_data;
    logic [0:0]      out_row;
    logic [1:0]      out_col;

    systolic_rect_dpath #(.ROWS(R), .COLS(C), .NBITS(NB), .DBITS(DB), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .mac_en(mac_en), .acc_clr(acc_clr),
        .x_in(x_in), .x_wen(x_wen), .x_ren(x_ren), .x_full(x_full), .x_empty(x_empty),
        .w_in(w_in), .w_wen(w_wen), .w_ren(w_ren), .w_full(w_full), .w_empty(w_empty),
        .drain_start(drain_start), .drain_busy(drain_busy), .out_val(out_val),
        .out_rdy(out_rdy), .out_data(out_data), .out_row(out_row), .out_col(out_col)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // reference state
    logic [NB-1:0] xq [R][$];
    logic [NB-1:0] wq [C][$];
    logic [NB-1:0] xh [R][HMAX];
    logic [NB-1:0] wh [C][HMAX];
    logic [NB-1:0] macc [R][C];
    logic [NB-1:0] mshadow [R][C];
    int  mstep = 0;
    bit  mbusy = 0;
    int  midx = 0;

    logic [NB-1:0] bq_data[$];
    int            bq_row[$];
    int            bq_col[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [NB-1:0] qmul(input logic [NB-1:0] a, input logic [NB-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> DB;
        return p[NB-1:0];
    endfunction

    // One clock edge of the reference. PE(i,j) at step s multiplies the x fed
    // to row i at step s-j by the w fed to column j at step s-i.
    task automatic model_step();
        logic [NB-1:0] xf [R];
        logic [NB-1:0] wf [C];
        logic [NB-1:0] xo, wo;
        bit push_ok;
        if (rst) begin
            for (int i = 0; i < R; i++) xq[i].delete();
            for (int j = 0; j < C; j++) wq[j].delete();
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++) macc[i][j] = '0;
            mbusy = 0; midx = 0; mstep = 0;
            return;
        end
        if (!mbusy) begin
            if (drain_start) begin
                for (int i = 0; i < R; i++)
                    for (int j = 0; j < C; j++) mshadow[i][j] = macc[i][j];
                mbusy = 1; midx = 0;
            end
        end else if (out_rdy) begin
            midx++;
            if (midx == R*C) begin mbusy = 0; midx = 0; end
        end
        for (int i = 0; i < R; i++) begin
            xf[i] = '0;
            push_ok = x_wen[i] && (xq[i].size() < D);
            if (mac_en && x_ren[i] && xq[i].size() > 0) xf[i] = xq[i].pop_front();
            if (push_ok) xq[i].push_back(x_in[i*NB +: NB]);
        end
        for (int j = 0; j < C; j++) begin
            wf[j] = '0;
            push_ok = w_wen[j] && (wq[j].size() < D);
            if (mac_en && w_ren[j] && wq[j].size() > 0) wf[j] = wq[j].pop_front();
            if (push_ok) wq[j].push_back(w_in[j*NB +: NB]);
        end
        if (mac_en) begin
            if (mstep >= HMAX) begin
                $display("FAIL model_history actual=%0d required<%0d", mstep, HMAX);
                $fatal(1, "history overflow");
            end
            for (int i = 0; i < R; i++) xh[i][mstep] = xf[i];
            for (int j = 0; j < C; j++) wh[j][mstep] = wf[j];
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                if (acc_clr) macc[i][j] = '0;
                else if (mac_en) begin
                    xo = (mstep >= j) ? xh[i][mstep-j] : '0;
                    wo = (mstep >= i) ? wh[j][mstep-i] : '0;
                    macc[i][j] = macc[i][j] + qmul(xo, wo);
                end
            end
        if (mac_en) mstep++;
    endtask

    // Per-cycle comparison against the reference, plus beat capture.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < R; i++) begin
                chk($sformatf("x_full[%0d]", i),  32'(x_full[i]),  32'(xq[i].size() == D));
                chk($sformatf("x_empty[%0d]", i), 32'(x_empty[i]), 32'(xq[i].size() == 0));
            end
            for (int j = 0; j < C; j++) begin
                chk($sformatf("w_full[%0d]", j),  32'(w_full[j]),  32'(wq[j].size() == D));
                chk($sformatf("w_empty[%0d]", j), 32'(w_empty[j]), 32'(wq[j].size() == 0));
            end
            chk("drain_busy", 32'(drain_busy), 32'(mbusy));
            chk("out_val", 32'(out_val), 32'(mbusy));
            if (mbusy) begin
                chk("out_data", 32'(out_data), 32'(mshadow[midx / C][midx % C]));
                chk("out_row", 32'(out_row), midx / C);
                chk("out_col", 32'(out_col), midx % C);
            end
            if (!rst && out_val && out_rdy) begin
                bq_data.push_back(out_data);
                bq_row.push_back(int'(out_row));
                bq_col.push_back(int'(out_col));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        mac_en = 0; acc_clr = 0; drain_start = 0; out_rdy = 0;
        x_in = '0; x_wen = '0; x_ren = '0;
        w_in = '0; w_wen = '0; w_ren = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic push(input bit is_x, input int idx, input logic [NB-1:0] v);
        if (is_x) begin x_in[idx*NB +: NB] = v; x_wen[idx] = 1'b1; end
        else      begin w_in[idx*NB +: NB] = v; w_wen[idx] = 1'b1; end
        tick();
        x_wen = '0; w_wen = '0;
    endtask

    task automatic clear_beats();
        bq_data.delete(); bq_row.delete(); bq_col.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (bq_data.size() < n && k < budget) begin tick(); k++; end
        chk("beat_count", bq_data.size(), n);
    endtask

    task automatic drain_all();
        clear_beats();
        drain_start = 1; tick(); drain_start = 0;
        out_rdy = 1;
        wait_beats(R*C, 4*R*C);
        out_rdy = 0;
        chk("busy_after_drain", 32'(drain_busy), 32'h0);
    endtask

    logic [NB-1:0] exp6 [R*C] = '{16'h1300, 16'h1600, 16'h0000, 16'h2B00, 16'h3200, 16'h0000};
    int pat [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};

    task automatic check_tile(input string tag, input bit zeros);
        for (int k = 0; k < R*C; k++) begin
            chk($sformatf("%s_data%0d", tag, k), 32'(bq_data[k]), zeros ? 32'h0 : 32'(exp6[k]));
            chk($sformatf("%s_row%0d", tag, k), bq_row[k], k / C);
            chk($sformatf("%s_col%0d", tag, k), bq_col[k], k % C);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        chk("rst_x_empty", 32'(x_empty), 32'h3);
        chk("rst_w_empty", 32'(w_empty), 32'h7);
        chk("rst_x_full", 32'(x_full), 32'h0);
        chk("rst_w_full", 32'(w_full), 32'h0);
        chk("rst_out_val", 32'(out_val), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_drain_busy", 32'(drain_busy), 32'h0);
        chk("rst_out_rc", 32'({out_row, out_col}), 32'h0);
        chk_en = 1;
        tick();
        rst = 0;

        // FIFO fill/overflow/order: sum of x_k*w_k, k=1..4 -> 30.0
        for (int k = 1; k <= 4; k++) push(1, 0, NB'(k * 256));
        chk("fifo_x0_full", 32'(x_full[0]), 32'h1);
        push(1, 0, 16'h0500);
        chk("fifo_x0_full_after_drop", 32'(x_full[0]), 32'h1);
        for (int k = 1; k <= 4; k++) push(0, 0, NB'(k * 256));
        mac_en = 1; x_ren[0] = 1; w_ren[0] = 1;
        repeat (4) tick();
        chk("fifo_x0_empty", 32'(x_empty[0]), 32'h1);
        tick();
        clear_inputs();
        drain_all();
        chk("fifo_order_sum", 32'(bq_data[0]), 32'h1E00);

        // single MAC, positive and negative
        reset_dut();
        push(1, 0, 16'h0200); push(0, 0, 16'h0180);
        mac_en = 1; x_ren[0] = 1; w_ren[0] = 1; tick(); clear_inputs();
        drain_all();
        chk("mac_pos", 32'(bq_data[0]), 32'h0300);
        chk("mac_pos_rc", (bq_row[0] << 4) | bq_col[0], 0);
        reset_dut();
        push(1, 0, 16'hFF00); push(0, 0, 16'h0200);
        mac_en = 1; x_ren[0] = 1; w_ren[0] = 1; tick(); clear_inputs();
        drain_all();
        chk("mac_neg", 32'(bq_data[0]), 32'hFE00);

        // 2x2 tile with skewed feed
        reset_dut();
        x_in = {16'h0300, 16'h0100}; x_wen = 2'b11;
        w_in = {16'h0000, 16'h0600, 16'h0500}; w_wen = 3'b011; tick();
        x_in = {16'h0400, 16'h0200};
        w_in = {16'h0000, 16'h0800, 16'h0700}; tick();
        clear_inputs();
        for (int t = 0; t < 4; t++) begin
            mac_en = 1;
            x_ren = {1'(t >= 1), 1'b1};
            w_ren = {1'b0, 1'(t >= 1), 1'b1};
            tick();
        end
        clear_inputs();
        drain_all();
        check_tile("tile", 0);

        // backpressure with a stray drain_start mid-drain
        clear_beats();
        drain_start = 1; tick(); drain_start = 0;
        for (int p = 0; p < 9; p++) begin
            out_rdy = 1'(pat[p]);
            drain_start = (p == 2);
            tick();
        end
        clear_inputs();
        chk("bp_beats", bq_data.size(), 6);
        chk("bp_busy_fall", 32'(drain_busy), 32'h0);
        check_tile("bp", 0);

        // clear in the drain_start cycle: snapshot keeps the old sums
        clear_beats();
        acc_clr = 1; drain_start = 1; tick();
        acc_clr = 0; drain_start = 0; out_rdy = 1;
        wait_beats(R*C, 4*R*C);
        out_rdy = 0; tick();
        check_tile("clr_snap", 0);
        drain_all();
        check_tile("clr_zero", 1);

        // reset after two beats aborts the drain
        clear_beats();
        drain_start = 1; tick(); drain_start = 0;
        out_rdy = 1; tick(); tick();
        rst = 1; tick();
        chk("abort_out_val", 32'(out_val), 32'h0);
        chk("abort_busy", 32'(drain_busy), 32'h0);
        rst = 0;
        repeat (4) tick();
        chk("abort_beats", bq_data.size(), 2);
        clear_inputs();

        // randomized traffic
        reset_dut();
        for (int n = 0; n < 2000; n++) begin
            rst         = ($urandom_range(0, 499) == 0);
            mac_en      = ($urandom_range(0, 9) < 6);
            acc_clr     = ($urandom_range(0, 19) == 0);
            drain_start = ($urandom_range(0, 29) == 0);
            out_rdy     = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < R; i++) begin
                x_in[i*NB +: NB] = NB'($urandom);
                x_wen[i] = 1'($urandom_range(0, 1));
                x_ren[i] = 1'($urandom_range(0, 1));
            end
            for (int j = 0; j < C; j++) begin
                w_in[j*NB +: NB] = NB'($urandom);
                w_wen[j] = 1'($urandom_range(0, 1));
                w_ren[j] = 1'($urandom_range(0, 1));
            end
            tick();
        end
        clear_inputs();
        rst = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
